// File: rtl/ex_md_unit_if.sv
// Handshake and operand bundle between the EX-stage control/forwarding logic
// and the iterative multiply/divide unit.
interface ex_md_unit_if #(
  parameter int WIDTH = 32
);
  logic             clr;
  logic             start;
  logic             md_is_mult;
  logic             md_is_unsigned;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output clr, start, md_is_mult, md_is_unsigned, op_a, op_b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  clr, start, md_is_mult, md_is_unsigned, op_a, op_b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/ex_md_unit.sv
// Radix-2 iterative multiply (shift-add) / restoring divide producing HI/LO.
// Macro MD_DIV_EN enables the divider; without it divides still take full latency and return 0.
module ex_md_unit #(
  parameter int WIDTH = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  ex_md_unit_if.slave md
);
  // state | meaning
  // IDLE  | waiting for start
  // CALC  | one radix-2 iteration per cycle, WIDTH cycles
  // FIX   | sign correction, HI/LO load
  // DONE  | done pulse
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_is_mult, r_neg_res, r_busy, r_done;
`ifdef MD_DIV_EN
  logic               r_neg_rem, r_div0;
  logic [WIDTH-1:0]   r_a_raw;
`endif

  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_nxt, w_prod;

  assign w_a_neg = !md.md_is_unsigned && md.op_a[WIDTH-1];
  assign w_b_neg = !md.md_is_unsigned && md.op_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -md.op_a : md.op_a;
  assign w_b_mag = w_b_neg ? -md.op_b : md.op_b;

  // Carry out of the upper-half add becomes the new MSB after the shift.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};
  assign w_prod    = r_neg_res ? -r_acc : r_acc;

`ifdef MD_DIV_EN
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_div_nxt;

  // Shifted partial remainder needs one extra bit; the accepted difference always fits WIDTH.
  assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge      = w_rem_sh >= {1'b0, r_opnd};
  assign w_diff    = w_rem_sh[WIDTH-1:0] - r_opnd;
  assign w_div_nxt = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                          : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (md.start) w_next = CALC;
      CALC:    if (r_cnt == CW'(WIDTH-1)) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (md.clr) w_next = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      r_done  <= (w_next == DONE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_is_mult <= 1'b0;
      r_neg_res <= 1'b0;
`ifdef MD_DIV_EN
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_a_raw   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_next == CALC) begin
          r_cnt     <= '0;
          r_is_mult <= md.md_is_mult;
          r_neg_res <= w_a_neg ^ w_b_neg;
`ifdef MD_DIV_EN
          r_opnd    <= md.md_is_mult ? w_a_mag : w_b_mag;
          r_acc     <= {{WIDTH{1'b0}}, (md.md_is_mult ? w_b_mag : w_a_mag)};
          r_neg_rem <= w_a_neg;
          r_div0    <= (md.op_b == '0);
          r_a_raw   <= md.op_a;
`else
          r_opnd    <= w_a_mag;
          r_acc     <= {{WIDTH{1'b0}}, w_b_mag};
`endif
        end
        CALC: begin
          r_cnt <= r_cnt + CW'(1);
`ifdef MD_DIV_EN
          r_acc <= r_is_mult ? w_mul_nxt : w_div_nxt;
`else
          r_acc <= w_mul_nxt;
`endif
        end
        FIX: if (!md.clr) begin
          if (r_is_mult) begin
            {r_hi, r_lo} <= w_prod;
`ifdef MD_DIV_EN
          end else if (r_div0) begin
            r_hi <= r_a_raw;
            r_lo <= '1;
          end else begin
            r_hi <= r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            r_lo <= r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
`else
          end else begin
            r_hi <= '0;
            r_lo <= '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign md.busy = r_busy;
  assign md.done = r_done;
  assign md.hi   = r_hi;
  assign md.lo   = r_lo;
endmodule

// File: tb/tb_ex_md_unit.sv
// Self-checking bench for ex_md_unit: timeline/arithmetic reference model plus directed literal vectors.
module tb_ex_md_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ex_md_unit_if #(.WIDTH(W)) md();
  ex_md_unit #(.WIDTH(W)) dut (.i_clk(clk), .i_rst_n(rst_n), .md(md));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Divide results only exist when the divider is built in.
  function automatic logic [31:0] dv(input logic [31:0] x);
`ifdef MD_DIV_EN
    return x;
`else
    return (x == x) ? 32'h0 : 32'h0;
`endif
  endfunction

  // Reference arithmetic: returns {hi, lo}.
  function automatic logic [63:0] md_model(input logic mult, input logic uns,
                                           input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (mult) begin
      if (uns) p = {32'h0, a} * {32'h0, b};
      else     p = 64'(sa * sb);
      return p;
    end
`ifdef MD_DIV_EN
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (uns) begin
      q = a / b;
      r = a % b;
    end else begin
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[31:0];
      r  = sr[31:0];
    end
    return {r, q};
`else
    return 64'h0;
`endif
  endfunction

  // Timeline model: an accepted start at edge E0 keeps busy through E33, done after E33.
  bit          m_active = 1'b0;
  int          m_age    = 0;
  logic [31:0] exp_hi   = '0;
  logic [31:0] exp_lo   = '0;
  logic [63:0] pend     = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 1'b0;
      m_age    = 0;
      exp_hi   = '0;
      exp_lo   = '0;
    end else if (m_active) begin
      if (md.clr) m_active = 1'b0;
      else begin
        m_age++;
        if (m_age == W + 1) {exp_hi, exp_lo} = pend;
        if (m_age == W + 2) m_active = 1'b0;
      end
    end else if (md.start && !md.clr) begin
      m_active = 1'b1;
      m_age    = 0;
      pend     = md_model(md.md_is_mult, md.md_is_unsigned, md.op_a, md.op_b);
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cmp_busy", 64'(md.busy), 64'(m_active));
    chk("cmp_done", 64'(md.done), 64'(m_active && m_age == W + 1));
    chk("cmp_hi",   64'(md.hi),   64'(exp_hi));
    chk("cmp_lo",   64'(md.lo),   64'(exp_lo));
  end

  task automatic launch(input logic mult, input logic uns, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md.start = 1'b1; md.md_is_mult = mult; md.md_is_unsigned = uns;
    md.op_a = a; md.op_b = b;
    @(posedge clk);
    @(negedge clk);
    md.start = 1'b0;
  endtask

  task automatic do_op(input string name, input logic mult, input logic uns,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
    int n;
    launch(mult, uns, a, b);
    n = 0;
    while (md.done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_lat"}, 64'(n), 64'(W + 1));
    chk({name, "_hi"}, 64'(md.hi), 64'(eh));
    chk({name, "_lo"}, 64'(md.lo), 64'(el));
    @(negedge clk);
  endtask

  int dcnt;

  initial begin
    md.clr = 1'b0; md.start = 1'b0; md.md_is_mult = 1'b0; md.md_is_unsigned = 1'b0;
    md.op_a = '0; md.op_b = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(md.busy), 64'h0);
    chk("rst_done", 64'(md.done), 64'h0);
    chk("rst_hilo", {md.hi, md.lo}, 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_op("smul_m3x5",  1'b1, 1'b0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    do_op("umul_max",   1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("smul_m1m1",  1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    do_op("sdiv_m7_2",  1'b0, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, dv(32'hFFFF_FFFF), dv(32'hFFFF_FFFD));
    do_op("udiv_100_7", 1'b0, 1'b1, 32'd100, 32'd7, dv(32'd2), dv(32'd14));
    do_op("udiv_by0",   1'b0, 1'b1, 32'h1234_5678, 32'h0, dv(32'h1234_5678), dv(32'hFFFF_FFFF));
    do_op("sdiv_by0",   1'b0, 1'b0, 32'h8765_4321, 32'h0, dv(32'h8765_4321), dv(32'hFFFF_FFFF));
    do_op("sdiv_ovf",   1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, dv(32'h0), dv(32'h8000_0000));
    do_op("sdiv_7_m2",  1'b0, 1'b0, 32'd7, 32'hFFFF_FFFE, dv(32'h0000_0001), dv(32'hFFFF_FFFD));
    do_op("setup_ab",   1'b0, 1'b1, 32'h0000_00BA, 32'h0000_0010, dv(32'hA), dv(32'hB));

    // Flush in the middle of CALC: result registers keep the previous values.
    launch(1'b1, 1'b1, 32'd7, 32'd9);
    repeat (10) @(negedge clk);
    md.clr = 1'b1;
    @(negedge clk);
    md.clr = 1'b0;
    chk("clr_busy", 64'(md.busy), 64'h0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (md.done === 1'b1) dcnt++;
    end
    chk("clr_nodone", 64'(dcnt), 64'h0);
    chk("clr_hilo", {md.hi, md.lo}, {dv(32'hA), dv(32'hB)});

    // Second start while busy is dropped.
    launch(1'b1, 1'b1, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    md.start = 1'b1; md.op_a = 32'd5; md.op_b = 32'd6;
    @(negedge clk);
    md.start = 1'b0;
    dcnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (md.done === 1'b1) dcnt++;
    end
    chk("busy_start_done_cnt", 64'(dcnt), 64'h1);
    chk("busy_start_hilo", {md.hi, md.lo}, 64'd12);

    // clr and start together in IDLE: request dropped.
    @(negedge clk);
    md.start = 1'b1; md.clr = 1'b1; md.md_is_mult = 1'b1;
    @(negedge clk);
    md.start = 1'b0; md.clr = 1'b0;
    chk("clr_start_busy", 64'(md.busy), 64'h0);

    // Asynchronous reset mid-operation.
    launch(1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_0003);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(md.busy), 64'h0);
    chk("arst_done", 64'(md.done), 64'h0);
    chk("arst_hilo", {md.hi, md.lo}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst", 1'b1, 1'b1, 32'h0000_1234, 32'h0000_0010, 32'h0, 32'h0001_2340);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
